// File: rtl/bidsn_pkg.sv
// Shared types for the multi-bidder auction unit: FSM states, controller
// opcodes and controller error codes.
package bidsn_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    ROUND    = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    UNLOCK     = 3'd1,
    LOCK       = 3'd2,
    LOADCREDIT = 3'd3,
    SETMASK    = 3'd4,
    SETCOST    = 3'd5,
    SETRESERVE = 3'd6,
    BADOP      = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_LOCKED    = 3'd1,
    ERR_BADKEY    = 3'd2,
    ERR_BADOP     = 3'd3,
    ERR_NOTLOCKED = 3'd4,
    ERR_BADIDX    = 3'd5,
    ERR_BUSY      = 3'd6
  } err_t;

  // Width of the bidder-index field carried in LOADCREDIT operands.
  localparam int CFG_IDX_W = 4;

endpackage

// File: rtl/bidsn_max_arb.sv
// Combinational arbiter: picks the highest amount among valid requests,
// resolving equal amounts in favour of the lowest index.
module bidsn_max_arb
  import bidsn_pkg::*;
#(
  parameter int N     = 4,
  parameter int BW    = 16,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]    valid_i,
  input  logic [N*BW-1:0] amt_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [BW-1:0]   amt_o,
  output logic            valid_o
);

  logic [IDX_W-1:0] best_idx;
  logic [BW-1:0]    best_amt;
  logic             best_vld;

  always_comb begin
    best_idx = '0;
    best_amt = '0;
    best_vld = 1'b0;
    // Strict greater-than keeps the earliest (lowest) index on ties.
    for (int i = 0; i < N; i++) begin
      if (valid_i[i] && (!best_vld || (amt_i[i*BW +: BW] > best_amt))) begin
        best_vld = 1'b1;
        best_amt = amt_i[i*BW +: BW];
        best_idx = IDX_W'(i);
      end
    end
  end

  assign idx_o   = best_idx;
  assign amt_o   = best_amt;
  assign valid_o = best_vld;

endmodule

// File: rtl/bidsn_auction.sv
// Parametrised sealed-credit auction unit: key-protected configuration,
// per-bidder credit balances, rounds run while C_start is high.
module bidsn_auction
  import bidsn_pkg::*;
#(
  parameter int NUM_BIDDERS = 4,
  parameter int BID_WIDTH   = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_BIDDERS-1:0]           bid,
  input  logic [NUM_BIDDERS*BID_WIDTH-1:0] bidAmt,
  input  logic [NUM_BIDDERS-1:0]           retract,
  input  logic                             C_start,
  input  logic [2:0]                       C_op,
  input  logic [DATA_WIDTH-1:0]            C_data,
  output logic [NUM_BIDDERS-1:0]           bidAck,
  output logic [NUM_BIDDERS-1:0]           bidErr,
  output logic [2:0]                       err,
  output logic                             ready,
  output logic                             roundOver,
  output logic [NUM_BIDDERS-1:0]           winner,
  output logic [BID_WIDTH-1:0]             maxBid,
  output logic [NUM_BIDDERS*BID_WIDTH-1:0] balance
);

  localparam int IDX_W = (NUM_BIDDERS > 1) ? $clog2(NUM_BIDDERS) : 1;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  key_q, key_d;
  logic [NUM_BIDDERS-1:0] mask_q, mask_d;
  logic [BID_WIDTH-1:0]   cost_q, cost_d;
  logic [BID_WIDTH-1:0]   reserve_q, reserve_d;
  err_t                   err_q, err_d;
  logic [BID_WIDTH-1:0]   balance_q [NUM_BIDDERS];
  logic [BID_WIDTH-1:0]   balance_d [NUM_BIDDERS];
  logic [BID_WIDTH-1:0]   maxbid_q, maxbid_d;
  logic [IDX_W-1:0]       leader_q, leader_d;
  logic                   leader_vld_q, leader_vld_d;
  logic [NUM_BIDDERS-1:0] winner_q, winner_d;
  logic [NUM_BIDDERS-1:0] part_q, part_d;
  logic [NUM_BIDDERS-1:0] ack_q, ack_d;
  logic [NUM_BIDDERS-1:0] berr_q, berr_d;
  logic                   rover_q, rover_d;

  logic [BID_WIDTH-1:0]   amt_w [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0] accept_w, reject_w, leader_oh_w;
  logic [IDX_W-1:0]       arb_idx_w;
  logic [BID_WIDTH-1:0]   arb_amt_w;
  logic                   arb_vld_w;
  logic [CFG_IDX_W-1:0]   cfg_idx_w;
  opcode_t                op_w;

  assign op_w        = opcode_t'(C_op);
  assign cfg_idx_w   = C_data[BID_WIDTH +: CFG_IDX_W];
  assign leader_oh_w = leader_vld_q ? (NUM_BIDDERS'(1) << leader_q) : '0;

  generate
    for (genvar gi = 0; gi < NUM_BIDDERS; gi++) begin : g_bidder
      assign amt_w[gi]                         = bidAmt[gi*BID_WIDTH +: BID_WIDTH];
      assign balance[gi*BID_WIDTH +: BID_WIDTH] = balance_q[gi];
    end
  endgenerate

  // Retract wins over a same-cycle bid; affordability uses one extra bit so
  // cost+amount cannot wrap.
  always_comb begin
    accept_w = '0;
    reject_w = '0;
    if (state_q == ROUND) begin
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        if (retract[i]) begin
          reject_w[i] = leader_oh_w[i];
        end else if (bid[i]) begin
          if (part_q[i] && (amt_w[i] > maxbid_q) &&
              (({1'b0, cost_q} + {1'b0, amt_w[i]}) <= {1'b0, balance_q[i]}))
            accept_w[i] = 1'b1;
          else
            reject_w[i] = 1'b1;
        end
      end
    end
  end

  bidsn_max_arb #(
    .N    (NUM_BIDDERS),
    .BW   (BID_WIDTH),
    .IDX_W(IDX_W)
  ) u_arb (
    .valid_i(accept_w),
    .amt_i  (bidAmt),
    .idx_o  (arb_idx_w),
    .amt_o  (arb_amt_w),
    .valid_o(arb_vld_w)
  );

  always_comb begin
    logic [BID_WIDTH:0] sum_v;
    logic               idx_hit;
    sum_v        = '0;
    idx_hit      = 1'b0;
    state_d      = state_q;
    key_d        = key_q;
    mask_d       = mask_q;
    cost_d       = cost_q;
    reserve_d    = reserve_q;
    err_d        = err_q;
    balance_d    = balance_q;
    maxbid_d     = maxbid_q;
    leader_d     = leader_q;
    leader_vld_d = leader_vld_q;
    winner_d     = winner_q;
    part_d       = part_q;
    ack_d        = '0;
    berr_d       = '0;
    rover_d      = 1'b0;

    unique case (state_q)
      UNLOCKED: begin
        if (op_w != NOP) begin
          err_d = ERR_NONE;
          unique case (op_w)
            LOCK: begin
              key_d   = C_data;
              state_d = LOCKED;
            end
            LOADCREDIT: begin
              for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (cfg_idx_w == CFG_IDX_W'(i)) begin
                  idx_hit      = 1'b1;
                  sum_v        = {1'b0, balance_q[i]} + {1'b0, C_data[BID_WIDTH-1:0]};
                  balance_d[i] = sum_v[BID_WIDTH] ? '1 : sum_v[BID_WIDTH-1:0];
                end
              end
              if (!idx_hit) err_d = ERR_BADIDX;
            end
            SETMASK:    mask_d    = C_data[NUM_BIDDERS-1:0];
            SETCOST:    cost_d    = C_data[BID_WIDTH-1:0];
            SETRESERVE: reserve_d = C_data[BID_WIDTH-1:0];
            BADOP:      err_d     = ERR_BADOP;
            default:    ;
          endcase
        end else if (C_start) begin
          err_d = ERR_NOTLOCKED;
        end
      end

      LOCKED: begin
        if (C_start) begin
          state_d      = ROUND;
          maxbid_d     = '0;
          leader_d     = '0;
          leader_vld_d = 1'b0;
          winner_d     = '0;
          part_d       = mask_q;
        end else if (op_w != NOP) begin
          unique case (op_w)
            UNLOCK: begin
              if (C_data == key_q) begin
                state_d = UNLOCKED;
                err_d   = ERR_NONE;
              end else begin
                err_d = ERR_BADKEY;
              end
            end
            BADOP:   err_d = ERR_BADOP;
            default: err_d = ERR_LOCKED;
          endcase
        end
      end

      ROUND: begin
        if (op_w != NOP) err_d = ERR_BUSY;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
          if (retract[i] && !leader_oh_w[i]) part_d[i] = 1'b0;
          if (accept_w[i]) balance_d[i] = balance_q[i] - cost_q;
        end
        ack_d  = accept_w;
        berr_d = reject_w;
        if (arb_vld_w) begin
          maxbid_d     = arb_amt_w;
          leader_d     = arb_idx_w;
          leader_vld_d = 1'b1;
        end
        if (!C_start) state_d = SETTLE;
      end

      SETTLE: begin
        if (op_w != NOP) err_d = ERR_BUSY;
        if (leader_vld_q && (maxbid_q >= reserve_q)) begin
          winner_d = leader_oh_w;
          for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (leader_oh_w[i]) balance_d[i] = balance_q[i] - maxbid_q;
          end
        end else begin
          winner_d = '0;
          maxbid_d = '0;
        end
        rover_d = 1'b1;
        state_d = LOCKED;
      end

      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      key_q        <= '0;
      mask_q       <= '1;
      cost_q       <= BID_WIDTH'(1);
      reserve_q    <= '0;
      err_q        <= ERR_NONE;
      maxbid_q     <= '0;
      leader_q     <= '0;
      leader_vld_q <= 1'b0;
      winner_q     <= '0;
      part_q       <= '0;
      ack_q        <= '0;
      berr_q       <= '0;
      rover_q      <= 1'b0;
      for (int i = 0; i < NUM_BIDDERS; i++) balance_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      cost_q       <= cost_d;
      reserve_q    <= reserve_d;
      err_q        <= err_d;
      maxbid_q     <= maxbid_d;
      leader_q     <= leader_d;
      leader_vld_q <= leader_vld_d;
      winner_q     <= winner_d;
      part_q       <= part_d;
      ack_q        <= ack_d;
      berr_q       <= berr_d;
      rover_q      <= rover_d;
      for (int i = 0; i < NUM_BIDDERS; i++) balance_q[i] <= balance_d[i];
    end
  end

  assign bidAck    = ack_q;
  assign bidErr    = berr_q;
  assign err       = err_q;
  assign ready     = (state_q == UNLOCKED) || (state_q == LOCKED);
  assign roundOver = rover_q;
  assign winner    = winner_q;
  assign maxBid    = maxbid_q;

endmodule

// File: tb/tb_bidsn_auction.sv
// Directed bench for bidsn_auction: configuration, lock/key, rounds,
// arbitration, retract rules, reserve, error codes and reset.
module tb_bidsn_auction;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    bid, retract;
  logic [N*BW-1:0] bidAmt;
  logic            C_start;
  logic [2:0]      C_op;
  logic [DW-1:0]   C_data;
  logic [N-1:0]    bidAck, bidErr, winner;
  logic [2:0]      err;
  logic            ready, roundOver;
  logic [BW-1:0]   maxBid;
  logic [N*BW-1:0] balance;

  int n_checks = 0;
  int n_fail   = 0;

  bidsn_auction #(.NUM_BIDDERS(N), .BID_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bid(bid), .bidAmt(bidAmt), .retract(retract),
    .C_start(C_start), .C_op(C_op), .C_data(C_data), .bidAck(bidAck),
    .bidErr(bidErr), .err(err), .ready(ready), .roundOver(roundOver),
    .winner(winner), .maxBid(maxBid), .balance(balance)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [DW-1:0] d);
    C_op = op; C_data = d;
    step();
    C_op = 3'd0; C_data = '0;
  endtask

  task automatic credit(input int idx, input int amt);
    do_op(3'd3, DW'((idx << 16) | amt));
  endtask

  task automatic set_bid(input int i, input int amt);
    bid[i] = 1'b1;
    bidAmt[i*BW +: BW] = BW'(amt);
  endtask

  task automatic clear_bids();
    bid = '0; retract = '0; bidAmt = '0;
  endtask

  task automatic wait_round_over(input string tag);
    int k;
    k = 0;
    while (roundOver !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    n_checks++; if (roundOver !== 1'b1) begin n_fail++; $display("FAIL %s_roundover: got %b expected 1 within 8 cycles", tag, roundOver); end
  endtask

  task automatic test_reset();
    reset = 1'b1; C_start = 1'b0; C_op = 3'd0; C_data = '0; clear_bids();
    step(); step();
    reset = 1'b0;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (err !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
    n_checks++; if (winner !== 4'b0000) begin n_fail++; $display("FAIL reset_winner: got %b expected 0000", winner); end
    n_checks++; if (maxBid !== 16'd0) begin n_fail++; $display("FAIL reset_maxbid: got %0d expected 0", maxBid); end
    n_checks++; if (balance !== 64'd0) begin n_fail++; $display("FAIL reset_balance: got %h expected 0", balance); end
    n_checks++; if (bidAck !== 4'b0 || bidErr !== 4'b0 || roundOver !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got ack=%b berr=%b ro=%b expected all 0", bidAck, bidErr, roundOver); end
  endtask

  task automatic test_config_lock();
    credit(0, 100); credit(1, 100); credit(2, 100);
    n_checks++; if (balance !== {16'd0, 16'd100, 16'd100, 16'd100}) begin n_fail++; $display("FAIL cfg_credit: got %h expected 0000006400640064", balance); end
    credit(4, 5);
    n_checks++; if (err !== 3'd5) begin n_fail++; $display("FAIL cfg_badidx: got %0d expected 5", err); end
    n_checks++; if (balance !== {16'd0, 16'd100, 16'd100, 16'd100}) begin n_fail++; $display("FAIL cfg_badidx_bal: got %h expected unchanged", balance); end
    C_start = 1'b1; step(); C_start = 1'b0;
    n_checks++; if (err !== 3'd4) begin n_fail++; $display("FAIL cfg_notlocked: got %0d expected 4", err); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL cfg_notlocked_ready: got %b expected 1", ready); end
    credit(3, 10);
    do_op(3'd5, 32'd1);
    do_op(3'd2, 32'h56);
    n_checks++; if (err !== 3'd0 || ready !== 1'b1) begin n_fail++; $display("FAIL cfg_lock: got err=%0d ready=%b expected 0/1", err, ready); end
    do_op(3'd1, 32'h58);
    n_checks++; if (err !== 3'd2) begin n_fail++; $display("FAIL cfg_badkey: got %0d expected 2", err); end
    credit(0, 5);
    n_checks++; if (err !== 3'd1) begin n_fail++; $display("FAIL cfg_locked_op: got %0d expected 1", err); end
    n_checks++; if (balance !== {16'd10, 16'd100, 16'd100, 16'd100}) begin n_fail++; $display("FAIL cfg_locked_bal: got %h expected 000a006400640064", balance); end
    do_op(3'd7, 32'd0);
    n_checks++; if (err !== 3'd3) begin n_fail++; $display("FAIL cfg_badop: got %0d expected 3", err); end
    do_op(3'd1, 32'h56);
    n_checks++; if (err !== 3'd0 || ready !== 1'b1) begin n_fail++; $display("FAIL cfg_unlock: got err=%0d ready=%b expected 0/1", err, ready); end
    do_op(3'd2, 32'h56);
  endtask

  task automatic test_basic_round();
    set_bid(0, 50); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0 || bidErr !== 4'b0) begin n_fail++; $display("FAIL basic_idle_bid: got ack=%b berr=%b expected 0000/0000", bidAck, bidErr); end
    C_start = 1'b1; step();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_round: got %b expected 0", ready); end
    set_bid(0, 10); set_bid(1, 20); set_bid(2, 30); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0111 || bidErr !== 4'b0) begin n_fail++; $display("FAIL basic_c1: got ack=%b berr=%b expected 0111/0000", bidAck, bidErr); end
    n_checks++; if (maxBid !== 16'd30) begin n_fail++; $display("FAIL basic_c1_max: got %0d expected 30", maxBid); end
    set_bid(0, 40); set_bid(1, 50); set_bid(2, 70); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0111 || bidErr !== 4'b0) begin n_fail++; $display("FAIL basic_c2: got ack=%b berr=%b expected 0111/0000", bidAck, bidErr); end
    n_checks++; if (balance !== {16'd10, 16'd98, 16'd98, 16'd98}) begin n_fail++; $display("FAIL basic_charge: got %h expected 000a006200620062", balance); end
    C_start = 1'b0; step();
    wait_round_over("basic");
    n_checks++; if (winner !== 4'b0100 || maxBid !== 16'd70) begin n_fail++; $display("FAIL basic_result: got winner=%b max=%0d expected 0100/70", winner, maxBid); end
    n_checks++; if (balance !== {16'd10, 16'd28, 16'd98, 16'd98}) begin n_fail++; $display("FAIL basic_settle: got %h expected 000a001c00620062", balance); end
    step();
    n_checks++; if (roundOver !== 1'b0 || winner !== 4'b0100 || ready !== 1'b1) begin n_fail++; $display("FAIL basic_after: got ro=%b winner=%b ready=%b expected 0/0100/1", roundOver, winner, ready); end
  endtask

  task automatic test_tie_credit();
    C_start = 1'b1; step();
    set_bid(1, 25); set_bid(2, 25); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0110 || maxBid !== 16'd25) begin n_fail++; $display("FAIL tie_ack: got ack=%b max=%0d expected 0110/25", bidAck, maxBid); end
    set_bid(3, 50); step(); clear_bids();
    n_checks++; if (bidErr !== 4'b1000 || bidAck !== 4'b0) begin n_fail++; $display("FAIL credit_reject: got berr=%b ack=%b expected 1000/0000", bidErr, bidAck); end
    n_checks++; if (balance[63:48] !== 16'd10) begin n_fail++; $display("FAIL credit_nocharge: got %0d expected 10", balance[63:48]); end
    C_start = 1'b0; step();
    wait_round_over("tie");
    n_checks++; if (winner !== 4'b0010 || maxBid !== 16'd25) begin n_fail++; $display("FAIL tie_winner: got winner=%b max=%0d expected 0010/25", winner, maxBid); end
    n_checks++; if (balance !== {16'd10, 16'd27, 16'd72, 16'd98}) begin n_fail++; $display("FAIL tie_settle: got %h expected 000a001b00480062", balance); end
  endtask

  task automatic test_retract();
    C_start = 1'b1; step();
    set_bid(0, 30); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0001) begin n_fail++; $display("FAIL retract_lead_bid: got %b expected 0001", bidAck); end
    retract[0] = 1'b1; step(); clear_bids();
    n_checks++; if (bidErr !== 4'b0001 || bidAck !== 4'b0) begin n_fail++; $display("FAIL retract_leader: got berr=%b ack=%b expected 0001/0000", bidErr, bidAck); end
    retract[1] = 1'b1; set_bid(1, 40); step(); clear_bids();
    n_checks++; if (bidErr !== 4'b0 || bidAck !== 4'b0 || maxBid !== 16'd30) begin n_fail++; $display("FAIL retract_same_cycle: got berr=%b ack=%b max=%0d expected 0000/0000/30", bidErr, bidAck, maxBid); end
    set_bid(1, 50); step(); clear_bids();
    n_checks++; if (bidErr !== 4'b0010 || bidAck !== 4'b0) begin n_fail++; $display("FAIL retract_withdrawn_bid: got berr=%b ack=%b expected 0010/0000", bidErr, bidAck); end
    C_start = 1'b0; step();
    wait_round_over("retract");
    n_checks++; if (winner !== 4'b0001 || maxBid !== 16'd30) begin n_fail++; $display("FAIL retract_winner: got winner=%b max=%0d expected 0001/30", winner, maxBid); end
    n_checks++; if (balance !== {16'd10, 16'd27, 16'd72, 16'd67}) begin n_fail++; $display("FAIL retract_settle: got %h expected 000a001b00480043", balance); end
  endtask

  task automatic test_reserve();
    do_op(3'd1, 32'h56); do_op(3'd6, 32'd100); do_op(3'd2, 32'h56);
    n_checks++; if (err !== 3'd0) begin n_fail++; $display("FAIL reserve_cfg: got %0d expected 0", err); end
    C_start = 1'b1; step();
    C_op = 3'd5; C_data = 32'd9; step(); C_op = 3'd0; C_data = '0;
    n_checks++; if (err !== 3'd6) begin n_fail++; $display("FAIL busy_op: got %0d expected 6", err); end
    set_bid(0, 60); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0001 || maxBid !== 16'd60) begin n_fail++; $display("FAIL reserve_bid: got ack=%b max=%0d expected 0001/60", bidAck, maxBid); end
    C_start = 1'b0; step();
    wait_round_over("reserve");
    n_checks++; if (winner !== 4'b0 || maxBid !== 16'd0) begin n_fail++; $display("FAIL reserve_nowin: got winner=%b max=%0d expected 0000/0", winner, maxBid); end
    n_checks++; if (balance !== {16'd10, 16'd27, 16'd72, 16'd66}) begin n_fail++; $display("FAIL reserve_charge: got %h expected 000a001b00480042", balance); end
  endtask

  task automatic test_reset_mid_round();
    C_start = 1'b1; step();
    set_bid(0, 10); step(); clear_bids();
    n_checks++; if (bidAck !== 4'b0001 || ready !== 1'b0) begin n_fail++; $display("FAIL midrst_bid: got ack=%b ready=%b expected 0001/0", bidAck, ready); end
    reset = 1'b1; step();
    n_checks++; if (ready !== 1'b1 || err !== 3'd0 || roundOver !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got ready=%b err=%0d ro=%b expected 1/0/0", ready, err, roundOver); end
    n_checks++; if (balance !== 64'd0 || maxBid !== 16'd0 || winner !== 4'b0 || bidAck !== 4'b0) begin n_fail++; $display("FAIL midrst_data: got bal=%h max=%0d winner=%b ack=%b expected all 0", balance, maxBid, winner, bidAck); end
    reset = 1'b0; C_start = 1'b0; step();
  endtask

  task automatic test_saturate();
    credit(0, 16'hFFF0); credit(0, 16'h0020);
    n_checks++; if (balance[15:0] !== 16'hFFFF || err !== 3'd0) begin n_fail++; $display("FAIL saturate: got bal=%h err=%0d expected ffff/0", balance[15:0], err); end
  endtask

  initial begin
    test_reset();
    test_config_lock();
    test_basic_round();
    test_tie_credit();
    test_retract();
    test_reserve();
    test_reset_mid_round();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
